calc_arbiter: RTL
=================

# calc_arbiter

Round-robin scheduler that shares one `top_level` calculator between `n_req` independent requesters. It accepts one operation at a time through a per-requester valid/ready handshake and drives the calculator's start/operand/function inputs. It waits for `done_o`, then returns the result to the granted requester through a held response handshake. The block sits between the requester ports and the calculator instance, replacing the fixed-operand stimulus used at bring-up.

## Interface
- `width`, 8: operand width; results are `2*width`
- `n_req`, 2: number of requesters, 2..4
- `timeout`, 255: maximum WAIT cycles before an error response, 1..255

- `clock_i` in 1: single clock, all logic on rising edge
- `reset_i` in 1: synchronous, active-high reset
- `req_valid_i` in n_req: requester i has an operation pending
- `req_ready_o` out n_req: one-hot accept pulse
- `req_a_i`, `req_b_i` in n_req*width: operands, slice i = bits [i*width +: width]
- `req_fct_i` in n_req*2: function; 00 add, 01 sub, 10 mul, 11 div
- `rsp_valid_o` out n_req: one-hot response valid
- `rsp_ready_i` in n_req: requester i takes its response
- `rsp_res_o`, `rsp_rem_o` out 2*width: shared response data
- `rsp_err_o` out 1: response is an error (div by zero or timeout)
- `calc_start_o` out 1: to calculator `start_i`
- `calc_a_o`, `calc_b_o` out width; `calc_fct_o` out 2: to calculator operands
- `calc_res_i`, `calc_rem_i` in 2*width; `calc_done_i` in 1: from calculator

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid_i`, grant the first valid index at or after `rr_ptr`, wrapping modulo n_req. In that same cycle, assert `req_ready_o[grant]` for exactly one cycle. Latch a/b/fct and the grant index.
  - If the latched fct = 11 and b = 0, go to RESP with `rsp_err_o`=1, res=0, rem=0, and do not start the calculator.
  - Otherwise go to ISSUE.
- ISSUE: `calc_start_o`=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT: the counter increments each cycle.
  - On `calc_done_i`=1, latch `calc_res_i`/`calc_rem_i`, set err=0, go to RESP.
  - Otherwise, if counter == timeout, set err=1, res=0, rem=0, go to RESP.
  - Done has priority over timeout in the same cycle.
- RESP: hold `rsp_valid_o[grant]`=1 and the data stable until `rsp_ready_i[grant]`=1. On that handshake, set `rr_ptr` = (grant+1) mod n_req and go to IDLE.
- `calc_done_i` is ignored outside WAIT. `rsp_ready_i` of non-granted requesters is ignored.
- `calc_a_o`/`calc_b_o`/`calc_fct_o` hold the latched values from the accept cycle until the next accept.
- Requests that are valid but not granted wait; requesters hold their operands until `req_ready_o` is asserted.
- Reset values: state IDLE, `rr_ptr`=0; all outputs 0, including `calc_start_o`, `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, and all data buses.
- Reset mid-operation: return to IDLE next cycle and drop the pending response. The calculator shares `reset_i`, so no stale done can reach a later op.

## Timing
- Accept in cycle T (IDLE) → `calc_start_o` in T+1 → WAIT from T+2.
- A done seen in cycle D gives `rsp_valid_o` from D+1.
- Div-by-zero: `rsp_valid_o` from T+1.
- Timeout: `rsp_valid_o` at T+2+timeout+1 when done never arrives.
- Response handshake in cycle H → IDLE in H+1 → next accept earliest H+1.
- At most one operation is in flight; throughput is one op per (calculator latency + 3) cycles minimum.
- `req_ready_o` and `rsp_valid_o` are registered-state-decoded; they do not depend combinationally on `rsp_ready_i`.

## Test plan
- req0 valid, a=3, b=7, fct=00, `calc_done_i` from the real calculator: one `req_ready_o[0]` pulse, one `calc_start_o` pulse, `rsp_valid_o[0]` with res=10, rem=0, err=0.
- req0 and req1 valid in the same cycle, `rr_ptr`=0, ops 5*6 and 20/3:
  - req0 is served first (res=30).
  - Then req1 (res=6, rem=2); `rr_ptr` ends at 0.
- req1 fct=11, b=0: no `calc_start_o`; `rsp_valid_o[1]` at T+1 with err=1, res=0, rem=0.
- `calc_done_i` tied low, timeout=4: `rsp_err_o`=1 with `rsp_valid_o` asserted exactly at T+7.
- `rsp_ready_i` held low 10 cycles after the response: `rsp_valid_o` and data stable throughout; no new accept until the handshake.
- `reset_i` pulsed during WAIT: the next cycle shows all outputs 0, state IDLE, `rr_ptr`=0; a subsequent request completes normally.

Source files
------------

// File: rtl/calc_arbiter.sv
// Round-robin front end sharing one calculator between n_req requesters:
// accept one op, start the calculator, await done (with watchdog), return a held response.
module calc_arbiter #(
    parameter int unsigned width   = 8,
    parameter int unsigned n_req   = 2,
    parameter int unsigned timeout = 255
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [n_req-1:0]         req_valid_i,
    output logic [n_req-1:0]         req_ready_o,
    input  logic [n_req*width-1:0]   req_a_i,
    input  logic [n_req*width-1:0]   req_b_i,
    input  logic [n_req*2-1:0]       req_fct_i,
    output logic [n_req-1:0]         rsp_valid_o,
    input  logic [n_req-1:0]         rsp_ready_i,
    output logic [2*width-1:0]       rsp_res_o,
    output logic [2*width-1:0]       rsp_rem_o,
    output logic                     rsp_err_o,
    output logic                     calc_start_o,
    output logic [width-1:0]         calc_a_o,
    output logic [width-1:0]         calc_b_o,
    output logic [1:0]               calc_fct_o,
    input  logic [2*width-1:0]       calc_res_i,
    input  logic [2*width-1:0]       calc_rem_i,
    input  logic                     calc_done_i
);

    localparam int unsigned iw = (n_req > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [iw-1:0]   rr_ptr;
    logic [iw-1:0]   grant_q;
    logic [iw-1:0]   grant_sel;
    logic            found;
    logic            accept;
    logic            div_zero;
    logic [7:0]      cnt;
    logic [width-1:0] sel_a, sel_b;
    logic [1:0]      sel_fct;

    // First valid requester at or after rr_ptr, wrapping modulo n_req.
    always_comb begin
        int unsigned idx;
        found     = 1'b0;
        grant_sel = '0;
        idx       = 0;
        for (int unsigned k = 0; k < n_req; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= n_req) idx = idx - n_req;
            if (!found && req_valid_i[idx]) begin
                found     = 1'b1;
                grant_sel = iw'(idx);
            end
        end
    end

    assign sel_a    = req_a_i[grant_sel*width +: width];
    assign sel_b    = req_b_i[grant_sel*width +: width];
    assign sel_fct  = req_fct_i[grant_sel*2 +: 2];
    assign div_zero = (sel_fct == 2'b11) && (sel_b == '0);

    always_comb begin
        state_next  = state;
        req_ready_o = '0;
        rsp_valid_o = '0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (found && !reset_i) begin
                    accept                 = 1'b1;
                    req_ready_o[grant_sel] = 1'b1;
                    state_next             = div_zero ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (calc_done_i || cnt == 8'(timeout)) state_next = RESP;
            end
            RESP: begin
                rsp_valid_o[grant_q] = 1'b1;
                if (rsp_ready_i[grant_q]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign calc_start_o = (state == ISSUE);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_q    <= '0;
            cnt        <= '0;
            calc_a_o   <= '0;
            calc_b_o   <= '0;
            calc_fct_o <= '0;
            rsp_res_o  <= '0;
            rsp_rem_o  <= '0;
            rsp_err_o  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_q    <= grant_sel;
                        calc_a_o   <= sel_a;
                        calc_b_o   <= sel_b;
                        calc_fct_o <= sel_fct;
                        if (div_zero) begin
                            rsp_res_o <= '0;
                            rsp_rem_o <= '0;
                            rsp_err_o <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // done wins over a watchdog expiry in the same cycle
                    if (calc_done_i) begin
                        rsp_res_o <= calc_res_i;
                        rsp_rem_o <= calc_rem_i;
                        rsp_err_o <= 1'b0;
                    end else if (cnt == 8'(timeout)) begin
                        rsp_res_o <= '0;
                        rsp_rem_o <= '0;
                        rsp_err_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[grant_q])
                        rr_ptr <= (int'(grant_q) == n_req - 1) ? '0 : grant_q + iw'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
